// File: rtl/player_core_if.sv
// Signal bundle between a player_core and its surroundings (keyboard decode, collision unit, renderer).
// The master side drives game/collision/raster inputs; the slave side is the player controller.
interface player_core_if #(
  parameter int SCORE_W = 7
);
  logic               SpawnEnable;
  logic               PlayerHit;
  logic [1:0]         PlayerCollect;
  logic               Deposit;
  logic [2:0]         Speed;
  logic [7:0]         Keycode;
  logic [9:0]         DrawX;
  logic [9:0]         DrawY;
  logic               Dead;
  logic               Full;
  logic               Shielded;
  logic               PlayerPixel;
  logic [6:0]         Tile;
  logic [4:0]         PixelX;
  logic [4:0]         PixelY;
  logic [4:0]         HbOffset;
  logic [SCORE_W-1:0] Score;
  logic [9:0]         PlayerX;
  logic [9:0]         PlayerY;

  modport master (
    output SpawnEnable, PlayerHit, PlayerCollect, Deposit, Speed, Keycode, DrawX, DrawY,
    input  Dead, Full, Shielded, PlayerPixel, Tile, PixelX, PixelY, HbOffset, Score,
           PlayerX, PlayerY
  );

  modport slave (
    input  SpawnEnable, PlayerHit, PlayerCollect, Deposit, Speed, Keycode, DrawX, DrawY,
    output Dead, Full, Shielded, PlayerPixel, Tile, PixelX, PixelY, HbOffset, Score,
           PlayerX, PlayerY
  );
endinterface

// File: rtl/player_core.sv
// Per-player controller: spawn, movement, animation, death/respawn, item carry and scoring.
// Define RESPAWN_SHIELD_EN to add a post-spawn invulnerability window.
module player_core #(
  parameter int PLAYER_IDX      = 0,
  parameter bit SPAWN_FACE_LEFT = 1'b0,
  parameter int MAX_ITEMS       = 3,
  parameter int TILES_PER_ANIM  = 8,
  parameter int FRAMES_PER_TILE = 5,
  parameter int DEATH_TICKS     = 60,
  parameter int MOVE_DIV        = 2,
  parameter int SHIELD_FRAMES   = 120,
  parameter int SCORE_W         = 7,
  parameter int P_W             = 32,
  parameter int P_H             = 32,
  parameter int MIN_X           = 100,
  parameter int MAX_X           = 739,
  parameter int MIN_Y           = 65,
  parameter int MAX_Y           = 448,
  parameter int SPAWN_X         = 292,
  parameter int SPAWN_Y         = 400
) (
  input logic          FrameClk,
  input logic          ResetN,
  player_core_if.slave bus
);

  localparam int ITEM_W    = $clog2(MAX_ITEMS + 1);
  localparam int VALUE_W   = $clog2(3 * MAX_ITEMS + 1);
  localparam int FRAME_W   = $clog2(FRAMES_PER_TILE + 1);
  localparam int TILE_W    = $clog2(TILES_PER_ANIM + 1);
  localparam int DEATH_W   = $clog2(DEATH_TICKS + 1);
  localparam int MOVE_W    = $clog2(MOVE_DIV + 1);
  localparam int X_HI      = MAX_X - P_W;
  localparam int Y_HI      = MAX_Y - P_H;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  // Numeric codes of the live states double as the tile bank index.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WALK    = 3'd1,
    DYING   = 3'd2,
    PENALTY = 3'd3,
    OFF     = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [9:0]         pos_x, pos_x_n, pos_y, pos_y_n;
  logic               face_left, face_left_n;
  logic [FRAME_W-1:0] frame_cnt, frame_cnt_n;
  logic [TILE_W-1:0]  tile_cnt, tile_cnt_n;
  logic [DEATH_W-1:0] death_cnt, death_cnt_n;
  logic [MOVE_W-1:0]  move_cnt, move_cnt_n;
  logic [ITEM_W-1:0]  items, items_n;
  logic [VALUE_W-1:0] value, value_n;
  logic [SCORE_W-1:0] score, score_n;
  logic               shielded;

  logic [3:0] keys;
  logic       left, right, up, down;
  logic       tick, tile_last, death_last, move_now, hit;
  int         eff_spd, x_try, y_try, score_sum, rel_x, rel_y;
  logic       in_sprite;

  // Only one nibble of the shared keycode belongs to this player.
  logic unused_keys;
  assign unused_keys = ^bus.Keycode;

  assign keys                    = bus.Keycode[4*PLAYER_IDX +: 4];
  assign {left, right, up, down} = keys;
  assign tick       = (frame_cnt == FRAME_W'(FRAMES_PER_TILE - 1));
  assign tile_last  = (tile_cnt == TILE_W'(TILES_PER_ANIM - 1));
  assign death_last = (death_cnt == DEATH_W'(DEATH_TICKS - 1));
  assign move_now   = (move_cnt == MOVE_W'(MOVE_DIV - 1));
  assign hit        = bus.PlayerHit && !shielded;

`ifdef RESPAWN_SHIELD_EN
  localparam int SHIELD_W = $clog2(SHIELD_FRAMES + 1);
  logic [SHIELD_W-1:0] shield_cnt, shield_cnt_n;

  always_comb begin
    shield_cnt_n = shield_cnt;
    if (!bus.SpawnEnable)       shield_cnt_n = '0;
    else if (state == OFF)      shield_cnt_n = SHIELD_W'(SHIELD_FRAMES);
    else if (shield_cnt != '0)  shield_cnt_n = shield_cnt - 1'b1;
  end

  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) shield_cnt <= '0;
    else         shield_cnt <= shield_cnt_n;
  end

  assign shielded = (shield_cnt != '0);
`else
  logic [31:0] unused_shield_cfg;
  assign unused_shield_cfg = SHIELD_FRAMES;
  assign shielded          = 1'b0;
`endif

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) state <= OFF;
    else         state <= state_n;
  end

  always_ff @(posedge FrameClk or negedge ResetN) begin
    if (!ResetN) begin
      pos_x     <= 10'(SPAWN_X);
      pos_y     <= 10'(SPAWN_Y);
      face_left <= 1'b0;
      frame_cnt <= '0;
      tile_cnt  <= '0;
      death_cnt <= '0;
      move_cnt  <= '0;
      items     <= '0;
      value     <= '0;
      score     <= '0;
    end else begin
      pos_x     <= pos_x_n;
      pos_y     <= pos_y_n;
      face_left <= face_left_n;
      frame_cnt <= frame_cnt_n;
      tile_cnt  <= tile_cnt_n;
      death_cnt <= death_cnt_n;
      move_cnt  <= move_cnt_n;
      items     <= items_n;
      value     <= value_n;
      score     <= score_n;
    end
  end

  // NOTE: every variable gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    pos_x_n     = pos_x;
    pos_y_n     = pos_y;
    face_left_n = face_left;
    frame_cnt_n = frame_cnt;
    tile_cnt_n  = tile_cnt;
    death_cnt_n = death_cnt;
    move_cnt_n  = move_cnt;
    items_n     = items;
    value_n     = value;
    score_n     = score;
    eff_spd     = int'(bus.Speed) - int'(items);
    if (eff_spd < 0) eff_spd = 0;
    x_try       = int'(pos_x);
    y_try       = int'(pos_y);
    score_sum   = int'(score) + int'(value);

    if (!bus.SpawnEnable) begin
      state_n = OFF;
      score_n = '0;
      items_n = '0;
      value_n = '0;
    end else begin
      unique case (state)
        OFF: begin
          state_n     = IDLE;
          pos_x_n     = 10'(SPAWN_X);
          pos_y_n     = 10'(SPAWN_Y);
          face_left_n = SPAWN_FACE_LEFT;
          items_n     = '0;
          value_n     = '0;
          frame_cnt_n = '0;
          tile_cnt_n  = '0;
          death_cnt_n = '0;
          move_cnt_n  = '0;
        end
        IDLE, WALK: begin
          frame_cnt_n = tick ? '0 : frame_cnt + 1'b1;
          if (tick) tile_cnt_n = tile_last ? '0 : tile_cnt + 1'b1;
          if (hit) begin
            // Carried items stay visible while dying and are dropped at respawn.
            state_n     = DYING;
            frame_cnt_n = '0;
            tile_cnt_n  = '0;
          end else begin
            move_cnt_n = move_now ? '0 : move_cnt + 1'b1;
            if (move_now) begin
              if (left ^ right) begin
                face_left_n = left;
                if (left) x_try = (x_try - eff_spd < MIN_X) ? MIN_X : x_try - eff_spd;
                else      x_try = (x_try + eff_spd > X_HI)  ? X_HI  : x_try + eff_spd;
              end
              if (up ^ down) begin
                if (up) y_try = (y_try - eff_spd < MIN_Y) ? MIN_Y : y_try - eff_spd;
                else    y_try = (y_try + eff_spd > Y_HI)  ? Y_HI  : y_try + eff_spd;
              end
              pos_x_n = 10'(x_try);
              pos_y_n = 10'(y_try);
              state_n = ((left ^ right) || (up ^ down)) ? WALK : IDLE;
            end
            if (bus.Deposit) begin
              score_n = (score_sum > SCORE_MAX) ? SCORE_W'(SCORE_MAX) : SCORE_W'(score_sum);
              items_n = '0;
              value_n = '0;
            end else if (bus.PlayerCollect != 2'd0 && items < ITEM_W'(MAX_ITEMS)) begin
              items_n = items + 1'b1;
              value_n = value + VALUE_W'(bus.PlayerCollect);
            end
          end
        end
        DYING: begin
          frame_cnt_n = tick ? '0 : frame_cnt + 1'b1;
          if (tick) begin
            if (tile_last) state_n    = PENALTY;
            else           tile_cnt_n = tile_cnt + 1'b1;
          end
        end
        PENALTY: begin
          frame_cnt_n = tick ? '0 : frame_cnt + 1'b1;
          if (tick) begin
            if (death_last) begin
              state_n     = OFF;
              death_cnt_n = '0;
            end else begin
              death_cnt_n = death_cnt + 1'b1;
            end
          end
        end
        default: state_n = OFF;
      endcase
    end
  end

  always_comb begin
    rel_x        = int'(bus.DrawX) - int'(pos_x);
    rel_y        = int'(bus.DrawY) - int'(pos_y);
    in_sprite    = (state != OFF) && (rel_x >= 0) && (rel_x < P_W) && (rel_y >= 0) && (rel_y < P_H);
    bus.PlayerPixel = in_sprite;
    bus.PixelX   = '0;
    bus.PixelY   = '0;
    if (in_sprite) begin
      bus.PixelX = face_left ? 5'(P_W - 1 - rel_x) : 5'(rel_x);
      bus.PixelY = 5'(rel_y);
    end
    bus.HbOffset = (state == OFF || face_left) ? 5'd0 : 5'(P_W / 2);
    bus.Tile     = (state == OFF) ? 7'd0
                 : 7'(int'(state) * TILES_PER_ANIM * (MAX_ITEMS + 1)
                      + int'(tile_cnt) * (MAX_ITEMS + 1) + int'(items));
    bus.Dead     = (state == DYING) || (state == PENALTY);
    bus.Full     = (items == ITEM_W'(MAX_ITEMS));
    bus.Shielded = shielded;
    bus.Score    = score;
    bus.PlayerX  = pos_x;
    bus.PlayerY  = pos_y;
  end

endmodule
